// File: rtl/rect_stream_receiver.sv
// Receives the 6-word-per-rectangle copy stream into the back bank of a
// double-buffered rectangle table and serves the front bank to the rasterizer.
module rect_stream_receiver #(
  parameter int COORD_WIDTH = 13,
  parameter int RECT_COUNT  = 64,
  parameter int IDX_WIDTH   = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   copy_start,
  input  logic [15:0]            stream_din,
  input  logic                   frame_swap,
  input  logic [IDX_WIDTH-1:0]   rd_index,
  output logic [COORD_WIDTH-1:0] rd_x,
  output logic [COORD_WIDTH-1:0] rd_y,
  output logic [COORD_WIDTH-1:0] rd_w,
  output logic [COORD_WIDTH-1:0] rd_h,
  output logic [15:0]            rd_color,
  output logic                   loading,
  output logic                   load_done,
  output logic                   bank_sel
);

  typedef enum logic {S_IDLE, S_LOAD} state_e;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COORD_WIDTH-1:0] w;
    logic [COORD_WIDTH-1:0] h;
    logic [15:0]            color;
  } rect_t;

  localparam int AW    = IDX_WIDTH + 1;
  localparam int DEPTH = 2 * RECT_COUNT;

  localparam logic [2:0] W_SEP   = 3'd0;
  localparam logic [2:0] W_X     = 3'd1;
  localparam logic [2:0] W_Y     = 3'd2;
  localparam logic [2:0] W_W     = 3'd3;
  localparam logic [2:0] W_H     = 3'd4;
  localparam logic [2:0] W_COLOR = 3'd5;

  localparam logic [IDX_WIDTH-1:0] LAST_RECT = IDX_WIDTH'(RECT_COUNT - 1);

  state_e               state_q, state_d;
  logic [2:0]           word_cnt_q, word_cnt_d;
  logic [IDX_WIDTH-1:0] rect_cnt_q, rect_cnt_d;
  logic                 bank_sel_q, bank_sel_d;
  logic                 pending_q, pending_d;
  logic                 loading_q, loading_d;
  logic                 load_done_q, load_done_d;
  rect_t                rd_q, rd_d;

  // Both banks share one array per field; the bank bit is the address MSB.
  logic [COORD_WIDTH-1:0] mem_x [DEPTH];
  logic [COORD_WIDTH-1:0] mem_y [DEPTH];
  logic [COORD_WIDTH-1:0] mem_w [DEPTH];
  logic [COORD_WIDTH-1:0] mem_h [DEPTH];
  logic [15:0]            mem_c [DEPTH];

  logic          in_load;
  logic          final_wr;
  logic          swap;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // A copy_start seen during LOAD restarts the stream, so that cycle writes nothing.
  assign in_load  = (state_q == S_LOAD) && !copy_start;
  assign final_wr = in_load && (word_cnt_q == W_COLOR) && (rect_cnt_q == LAST_RECT);
  assign swap     = frame_swap && (pending_q || final_wr);
  assign wr_en    = in_load && !reset && (word_cnt_q != W_SEP);
  assign wr_addr  = {~bank_sel_q, rect_cnt_q};
  assign rd_addr  = {bank_sel_q, rd_index};

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    rect_cnt_d  = rect_cnt_q;
    pending_d   = pending_q;
    bank_sel_d  = bank_sel_q ^ swap;
    if (swap) pending_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (copy_start) begin
          state_d    = S_LOAD;
          word_cnt_d = '0;
          rect_cnt_d = '0;
          pending_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (copy_start) begin
          word_cnt_d = '0;
          rect_cnt_d = '0;
        end else if (word_cnt_q == W_COLOR) begin
          word_cnt_d = '0;
          rect_cnt_d = rect_cnt_q + IDX_WIDTH'(1);
          if (rect_cnt_q == LAST_RECT) begin
            state_d   = S_IDLE;
            // A swap landing on the final word consumes the data immediately.
            pending_d = !frame_swap;
          end
        end else begin
          word_cnt_d = word_cnt_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    loading_d   = (state_d == S_LOAD);
    load_done_d = final_wr;
  end

  always_comb begin
    rd_d.x     = mem_x[rd_addr];
    rd_d.y     = mem_y[rd_addr];
    rd_d.w     = mem_w[rd_addr];
    rd_d.h     = mem_h[rd_addr];
    rd_d.color = mem_c[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      rect_cnt_q  <= '0;
      bank_sel_q  <= 1'b0;
      pending_q   <= 1'b0;
      loading_q   <= 1'b0;
      load_done_q <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      rect_cnt_q  <= rect_cnt_d;
      bank_sel_q  <= bank_sel_d;
      pending_q   <= pending_d;
      loading_q   <= loading_d;
      load_done_q <= load_done_d;
      rd_q        <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (word_cnt_q)
        W_X:     mem_x[wr_addr] <= stream_din[COORD_WIDTH-1:0];
        W_Y:     mem_y[wr_addr] <= stream_din[COORD_WIDTH-1:0];
        W_W:     mem_w[wr_addr] <= stream_din[COORD_WIDTH-1:0];
        W_H:     mem_h[wr_addr] <= stream_din[COORD_WIDTH-1:0];
        W_COLOR: mem_c[wr_addr] <= stream_din;
        default: ;
      endcase
    end
  end

  assign rd_x      = rd_q.x;
  assign rd_y      = rd_q.y;
  assign rd_w      = rd_q.w;
  assign rd_h      = rd_q.h;
  assign rd_color  = rd_q.color;
  assign loading   = loading_q;
  assign load_done = load_done_q;
  assign bank_sel  = bank_sel_q;

endmodule

// File: tb/tb_rect_stream_receiver.sv
// Randomized bench for rect_stream_receiver against a frame-level table model.
module tb_rect_stream_receiver;
  localparam int CW = 13;
  localparam int RC = 64;
  localparam int IW = 6;
  localparam int NW = 6 * RC;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          copy_start = 1'b0;
  logic [15:0]   stream_din = '0;
  logic          frame_swap = 1'b0;
  logic [IW-1:0] rd_index = '0;
  logic [CW-1:0] rd_x, rd_y, rd_w, rd_h;
  logic [15:0]   rd_color;
  logic          loading, load_done, bank_sel;

  rect_stream_receiver #(.COORD_WIDTH(CW), .RECT_COUNT(RC), .IDX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .copy_start(copy_start), .stream_din(stream_din),
    .frame_swap(frame_swap), .rd_index(rd_index), .rd_x(rd_x), .rd_y(rd_y),
    .rd_w(rd_w), .rd_h(rd_h), .rd_color(rd_color), .loading(loading),
    .load_done(load_done), .bank_sel(bank_sel));

  always #5 clk = ~clk;

  typedef struct {logic [15:0] x, y, w, h, c;} rect_t;
  rect_t cur [RC];
  rect_t tab [2][RC];
  bit    exp_bank = 1'b0;
  bit    exp_pend = 1'b0;

  int nchk = 0, nfail = 0;
  int cyc = 0, cnt_load = 0, cnt_done = 0, done_cyc = 0, start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (loading) cnt_load++;
    if (load_done) begin cnt_done++; done_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] word(input int k);
    rect_t r;
    r = cur[k / 6];
    case (k % 6)
      1: return r.x;
      2: return r.y;
      3: return r.w;
      4: return r.h;
      5: return r.c;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < RC; i++)
      cur[i] = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
  endtask

  task automatic rd_chk(input int idx);
    rect_t e;
    rd_index = IW'(idx);
    step();
    e = tab[exp_bank][idx];
    check("rd_x", 32'(rd_x), 32'(e.x[CW-1:0]));
    check("rd_y", 32'(rd_y), 32'(e.y[CW-1:0]));
    check("rd_w", 32'(rd_w), 32'(e.w[CW-1:0]));
    check("rd_h", 32'(rd_h), 32'(e.h[CW-1:0]));
    check("rd_color", 32'(rd_color), 32'(e.c));
  endtask

  task automatic do_swap();
    frame_swap = 1'b1;
    step();
    frame_swap = 1'b0;
    if (exp_pend) begin exp_bank = ~exp_bank; exp_pend = 1'b0; end
    check("swap_bank", 32'(bank_sel), 32'(exp_bank));
  endtask

  // Streams one full frame of cur[]; optional restart, mid-load swap, abort,
  // swap on the final word, or swap together with the start pulse.
  task automatic load(input int restart_at, input int swap_at, input int abort_at,
                      input bit final_swap, input bit start_swap);
    int k;
    bit rs;
    rs = 1'b0;
    cnt_load = 0;
    cnt_done = 0;
    copy_start = 1'b1;
    frame_swap = start_swap;
    step();
    copy_start = 1'b0;
    frame_swap = 1'b0;
    start_cyc = cyc;
    if (start_swap && exp_pend) exp_bank = ~exp_bank;
    exp_pend = 1'b0;
    check("start_bank", 32'(bank_sel), 32'(exp_bank));
    k = 0;
    while (k < NW) begin
      if (k == abort_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_bank = 1'b0;
        exp_pend = 1'b0;
        return;
      end
      if (k == restart_at && !rs) begin
        rs = 1'b1;
        fill_rand();
        copy_start = 1'b1;
        step();
        copy_start = 1'b0;
        start_cyc = cyc;
        k = 0;
        continue;
      end
      stream_din = word(k);
      frame_swap = (k == swap_at) || (final_swap && k == NW - 1);
      step();
      frame_swap = 1'b0;
      k++;
    end
    if (final_swap) begin
      exp_bank = ~exp_bank;
      tab[exp_bank] = cur;
    end else begin
      tab[~exp_bank] = cur;
      exp_pend = 1'b1;
    end
    step();
    check("done_cnt", 32'(cnt_done), 32'd1);
    check("done_lat", 32'(done_cyc - start_cyc), 32'(NW));
    check("load_len", 32'(cnt_load), rs ? 32'(restart_at + 1 + NW) : 32'(NW));
    check("end_bank", 32'(bank_sel), 32'(exp_bank));
  endtask

  initial begin
    step();
    step();
    check("rst_x", 32'(rd_x), 32'd0);
    check("rst_y", 32'(rd_y), 32'd0);
    check("rst_w", 32'(rd_w), 32'd0);
    check("rst_h", 32'(rd_h), 32'd0);
    check("rst_color", 32'(rd_color), 32'd0);
    check("rst_bank", 32'(bank_sel), 32'd0);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    reset = 1'b0;
    step();

    // Ramp pattern frame.
    for (int i = 0; i < RC; i++)
      cur[i] = '{16'(10 + i), 16'(20 + i), 16'(30 + i), 16'(40 + i), 16'(16'hF000 + i)};
    load(-1, -1, -1, 1'b0, 1'b0);
    do_swap();
    rd_chk(5);
    check("x5_const", 32'(rd_x), 32'd15);
    check("c5_const", 32'(rd_color), 32'hF005);
    for (int j = 0; j < 3; j++) rd_chk($urandom_range(0, RC - 1));

    // Swap during a load is ignored.
    fill_rand();
    for (int i = 0; i < RC; i++) cur[i].x = 16'h1FFF;
    load(-1, 150, -1, 1'b0, 1'b0);
    rd_chk(5);
    check("old_x5", 32'(rd_x), 32'd15);
    do_swap();
    rd_chk($urandom_range(0, RC - 1));
    check("new_x", 32'(rd_x), 32'h1FFF);

    // Coordinate truncation vs full-width color.
    fill_rand();
    cur[7].x = 16'hE005;
    cur[7].c = 16'hE005;
    load(-1, -1, -1, 1'b0, 1'b0);
    do_swap();
    rd_chk(7);
    check("trunc_x", 32'(rd_x), 32'h0005);
    check("full_color", 32'(rd_color), 32'hE005);

    // Restart mid-load with a fresh stream.
    fill_rand();
    load(100, -1, -1, 1'b0, 1'b0);
    do_swap();
    rd_chk(0);
    rd_chk($urandom_range(0, RC - 1));

    // Swap coinciding with the final word; a later swap has nothing pending.
    fill_rand();
    load(-1, -1, -1, 1'b1, 1'b0);
    rd_chk(0);
    rd_chk(RC - 1);
    do_swap();

    // Start pulse with swap while data is pending.
    fill_rand();
    load(-1, -1, -1, 1'b0, 1'b0);
    fill_rand();
    load(-1, -1, -1, 1'b0, 1'b1);
    rd_chk($urandom_range(0, RC - 1));
    do_swap();
    rd_chk($urandom_range(0, RC - 1));

    // Reset mid-load.
    fill_rand();
    load(-1, -1, 200, 1'b0, 1'b0);
    check("abort_loading", 32'(loading), 32'd0);
    check("abort_bank", 32'(bank_sel), 32'd0);
    repeat (10) step();
    check("abort_no_done", 32'(cnt_done), 32'd0);
    do_swap();

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
